voice_allocator: RTL and testbench
==================================

# voice_allocator

Assigns pressed keys to the three oscillator voices (period slots 1-3) that feed the square/sawtooth/triangle/sine generators and the output mixer. Consumes a press/release event stream (decoded upstream from the PIC SPI link) and keeps active notes packed in slots 1..notes, oldest in slot 1. It also drives the `notes` count the mixer uses, so unused slots never contribute. When all three voices are busy, the oldest note is stolen.

## Interface
- PW, 32, period width in clk cycles
- KW, 5, key index width
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ev_valid  in  1  event offered
- ev_ready  out  1  allocator can accept an event
- ev_press  in  1  1 = key press, 0 = key release
- ev_key  in  KW  key index
- ev_period  in  PW  oscillator period for the key; ignored on release
- prd1, prd2, prd3  out  PW  slot periods; 0 when the slot is empty
- notes  out  2  number of active voices, 0..3
- upd  out  1  one-cycle pulse when prd*/notes change
- steal  out  1  one-cycle pulse, coincident with upd, when the oldest voice was evicted

## Operation
- Internal state per slot: key[KW], period[PW], valid. prd*/notes are registered views of this state.
- FSM states:
  - IDLE: ev_ready=1. A transfer happens when ev_valid&&ev_ready at a clk edge. The event is latched and the FSM moves to SCAN with idx=0.
  - SCAN: ev_ready=0. Compares slot[idx] (valid && key==latched key) with one slot per cycle, idx 0,1,2. Records the first match index. After idx=2 the FSM goes to APPLY.
  - APPLY: ev_ready=0. Performs the update below, pulses upd/steal if applicable, then returns to IDLE.
- Update rules:
  - Press, match found: no change, no upd.
  - Press, ev_period==0: rejected, no change, no upd.
  - Press, no match, notes<3: write {key,period} to slot notes+1; notes+=1.
  - Press, no match, notes==3: slot2→slot1, slot3→slot2, new note→slot3; notes stays 3; steal=1.
  - Release, match at slot i: every slot j>i shifts to j-1; the top occupied slot is cleared (period 0, valid 0); notes-=1.
  - Release, no match: no change, no upd.
- Invariants:
  - Slots 1..notes are valid.
  - Slots above notes have period 0.
  - No duplicate keys.
  - Age order is preserved by every shift.
- Arithmetic: notes never wraps. A press at 3 steals; a release at 0 is unreachable because there is no match.

## Timing
- Reset (async assert, synchronous-safe deassert): FSM=IDLE, ev_ready=1, all slots invalid, prd1..3=0, notes=0, upd=0, steal=0.
- Latency: accept at edge T. SCAN occupies edges T+1..T+3 and APPLY is evaluated at edge T+4. New prd*/notes/upd/steal are visible after edge T+4. ev_ready is 1 again in the following cycle.
- Throughput: one event per 5 cycles. ev_ready is low for 4 cycles after each accept.
- Events offered while ev_ready=0 are not consumed. The upstream must hold ev_valid and its fields stable until accepted.
- ev_* are sampled only at the accept edge. Later changes do not affect an event in flight.
- prd*/notes change only at an APPLY edge, and all four change on the same edge. The mixer never sees a mismatched notes/prd pair.
- rst_n asserted mid-SCAN/APPLY: the event is dropped, state goes to the reset values immediately, and no upd follows.

## Test plan
- Reset, then press key 3 with period 1000: upd at accept+4; prd1=1000, notes=1, prd2=prd3=0; ev_ready low exactly 4 cycles.
- Press keys 1/2/3 (periods 100/200/300), then press key 4 (period 400): prd=300,200,... specifically prd1=200, prd2=300, prd3=400, notes=3, steal pulses once.
- With keys 1/2/3 active, release key 2: prd1=100, prd2=300, prd3=0, notes=2. Then release key 9 (unknown): no upd, outputs unchanged.
- Press key 5 twice with period 500, then press period-0 key 6: the second and third presses produce no upd; notes=1.
- Hold ev_valid high with a new event each cycle: exactly one accept per 5 cycles; no event lost or duplicated (scoreboard against a reference model).
- Assert rst_n low during SCAN after a press with 2 notes active: outputs 0 immediately; after release, ev_ready=1 and no upd pulse.

Source files
------------

// File: rtl/voice_allocator.sv
// voice_allocator: packs pressed keys into three oldest-first voice slots, stealing the oldest when full.
module voice_allocator #(
   parameter int PW = 32,
   parameter int KW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ev_valid,
   output logic          ev_ready,
   input  logic          ev_press,
   input  logic [KW-1:0] ev_key,
   input  logic [PW-1:0] ev_period,
   output logic [PW-1:0] prd1,
   output logic [PW-1:0] prd2,
   output logic [PW-1:0] prd3,
   output logic [1:0]    notes,
   output logic          upd,
   output logic          steal
);
   typedef enum logic [1:0] {IDLE, SCAN, APPLY} state_t;
   state_t        state_q, state_d;
   logic [1:0]    idx_q, idx_d, midx_q, midx_d, notes_q, notes_d;
   logic          found_q, found_d, lpress_q, lpress_d, upd_q, upd_d, steal_q, steal_d;
   logic [KW-1:0] lkey_q, lkey_d;
   logic [PW-1:0] lper_q, lper_d;
   logic [KW-1:0] key_q [3];
   logic [KW-1:0] key_d [3];
   logic [PW-1:0] per_q [3];
   logic [PW-1:0] per_d [3];
   logic [2:0]    vld_q, vld_d;
   logic          hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         midx_q   <= '0;
         notes_q  <= '0;
         found_q  <= 1'b0;
         lpress_q <= 1'b0;
         upd_q    <= 1'b0;
         steal_q  <= 1'b0;
         lkey_q   <= '0;
         lper_q   <= '0;
         key_q    <= '{default: '0};
         per_q    <= '{default: '0};
         vld_q    <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         midx_q   <= midx_d;
         notes_q  <= notes_d;
         found_q  <= found_d;
         lpress_q <= lpress_d;
         upd_q    <= upd_d;
         steal_q  <= steal_d;
         lkey_q   <= lkey_d;
         lper_q   <= lper_d;
         key_q    <= key_d;
         per_q    <= per_d;
         vld_q    <= vld_d;
      end
   end

   always_comb begin
      state_d = state_q == IDLE ? (ev_valid ? SCAN : IDLE) :
                state_q == SCAN ? (idx_q == 2'd2 ? APPLY : SCAN) : IDLE;
      idx_d   = state_q == SCAN ? idx_q + 2'd1 : 2'd0;
   end

   always_comb begin
      ev_ready = state_q == IDLE;
      prd1     = per_q[0];
      prd2     = per_q[1];
      prd3     = per_q[2];
      notes    = notes_q;
      upd      = upd_q;
      steal    = steal_q;
   end

   assign hit = vld_q[idx_q] && key_q[idx_q] == lkey_q;

   always_comb begin
      lpress_d = lpress_q;
      lkey_d   = lkey_q;
      lper_d   = lper_q;
      found_d  = found_q;
      midx_d   = midx_q;
      key_d    = key_q;
      per_d    = per_q;
      vld_d    = vld_q;
      notes_d  = notes_q;
      upd_d    = 1'b0;
      steal_d  = 1'b0;
      if (state_q == IDLE && ev_valid) begin
         lpress_d = ev_press;
         lkey_d   = ev_key;
         lper_d   = ev_period;
         found_d  = 1'b0;
         midx_d   = '0;
      end
      if (state_q == SCAN && !found_q && hit) begin
         found_d = 1'b1;
         midx_d  = idx_q;
      end
      if (state_q == APPLY) begin
         if (lpress_q && !found_q && lper_q != '0) begin
            upd_d = 1'b1;
            if (notes_q != 2'd3) begin
               key_d[notes_q] = lkey_q;
               per_d[notes_q] = lper_q;
               vld_d[notes_q] = 1'b1;
               notes_d        = notes_q + 2'd1;
            end else begin
               key_d   = '{key_q[1], key_q[2], lkey_q};
               per_d   = '{per_q[1], per_q[2], lper_q};
               vld_d   = 3'b111;
               steal_d = 1'b1;
            end
         end else if (!lpress_q && found_q) begin
            // slots above the top are already empty, so shifting them down clears the old top
            upd_d   = 1'b1;
            notes_d = notes_q - 2'd1;
            if (midx_q == 2'd0) begin
               key_d[0] = key_q[1];
               per_d[0] = per_q[1];
               vld_d[0] = vld_q[1];
            end
            if (midx_q < 2'd2) begin
               key_d[1] = key_q[2];
               per_d[1] = per_q[2];
               vld_d[1] = vld_q[2];
            end
            key_d[2] = '0;
            per_d[2] = '0;
            vld_d[2] = 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: table-driven vectors plus reset, streaming and mid-scan reset sequences.
module tb_voice_allocator;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ev_valid = 1'b0;
   logic        ev_ready;
   logic        ev_press = 1'b0;
   logic [4:0]  ev_key = '0;
   logic [31:0] ev_period = '0;
   logic [31:0] prd1, prd2, prd3;
   logic [1:0]  notes;
   logic        upd, steal;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      int press, key, per, up, st, n, p1, p2, p3;
   } vec_t;
   vec_t tbl[24];

   logic [4:0]  qk[$];
   logic [31:0] qp[$];

   voice_allocator #(.PW(32), .KW(5)) dut (
      .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
      .ev_press(ev_press), .ev_key(ev_key), .ev_period(ev_period),
      .prd1(prd1), .prd2(prd2), .prd3(prd3), .notes(notes), .upd(upd), .steal(steal)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d", nm, act, exp);
      end
   endtask

   // Reference: notes kept as an oldest-first queue.
   task automatic model(input logic p, input logic [4:0] k, input logic [31:0] per,
                        output logic eu, output logic es);
      int f = -1;
      eu = 1'b0;
      es = 1'b0;
      foreach (qk[i]) if (qk[i] == k && f < 0) f = i;
      if (p) begin
         if (f < 0 && per != 0) begin
            eu = 1'b1;
            if (qk.size() == 3) begin
               void'(qk.pop_front());
               void'(qp.pop_front());
               es = 1'b1;
            end
            qk.push_back(k);
            qp.push_back(per);
         end
      end else if (f >= 0) begin
         eu = 1'b1;
         qk.delete(f);
         qp.delete(f);
      end
   endtask

   function automatic logic [31:0] ep(input int i);
      return i < qp.size() ? qp[i] : 32'd0;
   endfunction

   task automatic do_event(input logic p, input logic [4:0] k, input logic [31:0] per, input logic keep,
                           output int wt, output int low, output logic rdy, output logic gu, output logic gs);
      logic early = 1'b0;
      ev_press  = p;
      ev_key    = k;
      ev_period = per;
      ev_valid  = 1'b1;
      wt = 0;
      while (!ev_ready && wt < 20) begin
         @(negedge clk);
         wt++;
      end
      @(posedge clk);
      #1;
      ev_valid  = keep;
      ev_press  = ~p;
      ev_key    = ~k;
      ev_period = per + 32'd7;
      low = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (!ev_ready) low++;
         if (upd) early = 1'b1;
      end
      chk("early_upd", {31'd0, early}, 32'd0);
      @(negedge clk);
      rdy = ev_ready;
      gu  = upd;
      gs  = steal;
      n_vec++;
   endtask

   initial begin
      int wt, low;
      logic rdy, gu, gs, eu, es, seen;
      tbl[0]  = '{1, 3, 1000, 1, 0, 1, 1000, 0, 0};
      tbl[1]  = '{0, 3, 0, 1, 0, 0, 0, 0, 0};
      tbl[2]  = '{1, 1, 100, 1, 0, 1, 100, 0, 0};
      tbl[3]  = '{1, 2, 200, 1, 0, 2, 100, 200, 0};
      tbl[4]  = '{1, 3, 300, 1, 0, 3, 100, 200, 300};
      tbl[5]  = '{0, 2, 0, 1, 0, 2, 100, 300, 0};
      tbl[6]  = '{0, 9, 0, 0, 0, 2, 100, 300, 0};
      tbl[7]  = '{1, 2, 200, 1, 0, 3, 100, 300, 200};
      tbl[8]  = '{1, 4, 400, 1, 1, 3, 300, 200, 400};
      tbl[9]  = '{1, 4, 999, 0, 0, 3, 300, 200, 400};
      tbl[10] = '{1, 6, 0, 0, 0, 3, 300, 200, 400};
      tbl[11] = '{0, 4, 0, 1, 0, 2, 300, 200, 0};
      tbl[12] = '{0, 1, 777, 0, 0, 2, 300, 200, 0};
      tbl[13] = '{0, 3, 0, 1, 0, 1, 200, 0, 0};
      tbl[14] = '{0, 2, 0, 1, 0, 0, 0, 0, 0};
      tbl[15] = '{1, 5, 500, 1, 0, 1, 500, 0, 0};
      tbl[16] = '{1, 5, 500, 0, 0, 1, 500, 0, 0};
      tbl[17] = '{1, 6, 0, 0, 0, 1, 500, 0, 0};
      tbl[18] = '{0, 5, 0, 1, 0, 0, 0, 0, 0};
      tbl[19] = '{1, 1, 100, 1, 0, 1, 100, 0, 0};
      tbl[20] = '{1, 2, 200, 1, 0, 2, 100, 200, 0};
      tbl[21] = '{1, 3, 300, 1, 0, 3, 100, 200, 300};
      tbl[22] = '{1, 4, 400, 1, 1, 3, 200, 300, 400};
      tbl[23] = '{0, 9, 0, 0, 0, 3, 200, 300, 400};

      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, ev_ready}, 32'd1);
      chk("rst_notes", {30'd0, notes}, 32'd0);
      chk("rst_prd1", prd1, 32'd0);
      chk("rst_prd3", prd3, 32'd0);
      chk("rst_upd", {31'd0, upd}, 32'd0);
      chk("rst_steal", {31'd0, steal}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (tbl[i]) begin
         do_event(tbl[i].press[0], 5'(tbl[i].key), 32'(tbl[i].per), 1'b0, wt, low, rdy, gu, gs);
         chk($sformatf("v%0d_wait", i), wt, 32'd0);
         chk($sformatf("v%0d_lowcycles", i), low, 32'd4);
         chk($sformatf("v%0d_ready", i), {31'd0, rdy}, 32'd1);
         chk($sformatf("v%0d_upd", i), {31'd0, gu}, 32'(tbl[i].up));
         chk($sformatf("v%0d_steal", i), {31'd0, gs}, 32'(tbl[i].st));
         chk($sformatf("v%0d_notes", i), {30'd0, notes}, 32'(tbl[i].n));
         chk($sformatf("v%0d_prd1", i), prd1, 32'(tbl[i].p1));
         chk($sformatf("v%0d_prd2", i), prd2, 32'(tbl[i].p2));
         chk($sformatf("v%0d_prd3", i), prd3, 32'(tbl[i].p3));
         @(negedge clk);
         chk($sformatf("v%0d_upd_pulse", i), {31'd0, upd}, 32'd0);
      end

      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      qk.delete();
      qp.delete();
      for (int i = 0; i < 24; i++) begin
         logic p;
         logic [4:0] k;
         logic [31:0] per;
         p   = $urandom_range(0, 3) != 0;
         k   = 5'($urandom_range(0, 5));
         per = 32'($urandom_range(0, 4) * 100);
         model(p, k, per, eu, es);
         do_event(p, k, per, i != 23, wt, low, rdy, gu, gs);
         chk($sformatf("s%0d_wait", i), wt, 32'd0);
         chk($sformatf("s%0d_lowcycles", i), low, 32'd4);
         chk($sformatf("s%0d_upd", i), {31'd0, gu}, {31'd0, eu});
         chk($sformatf("s%0d_steal", i), {31'd0, gs}, {31'd0, es});
         chk($sformatf("s%0d_notes", i), {30'd0, notes}, 32'(qk.size()));
         chk($sformatf("s%0d_prd1", i), prd1, ep(0));
         chk($sformatf("s%0d_prd2", i), prd2, ep(1));
         chk($sformatf("s%0d_prd3", i), prd3, ep(2));
      end
      @(negedge clk);

      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      do_event(1'b1, 5'd1, 32'd100, 1'b0, wt, low, rdy, gu, gs);
      do_event(1'b1, 5'd2, 32'd200, 1'b0, wt, low, rdy, gu, gs);
      chk("mid_pre_notes", {30'd0, notes}, 32'd2);
      ev_press  = 1'b1;
      ev_key    = 5'd3;
      ev_period = 32'd300;
      ev_valid  = 1'b1;
      @(posedge clk);
      #1;
      ev_valid = 1'b0;
      @(negedge clk);
      chk("mid_scan_ready", {31'd0, ev_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_prd1", prd1, 32'd0);
      chk("mid_rst_prd2", prd2, 32'd0);
      chk("mid_rst_notes", {30'd0, notes}, 32'd0);
      chk("mid_rst_ready", {31'd0, ev_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (upd) seen = 1'b1;
      end
      n_vec++;
      chk("mid_no_upd", {31'd0, seen}, 32'd0);
      chk("mid_post_ready", {31'd0, ev_ready}, 32'd1);
      chk("mid_post_notes", {30'd0, notes}, 32'd0);
      do_event(1'b1, 5'd7, 32'd700, 1'b0, wt, low, rdy, gu, gs);
      chk("mid_after_upd", {31'd0, gu}, 32'd1);
      chk("mid_after_notes", {30'd0, notes}, 32'd1);
      chk("mid_after_prd1", prd1, 32'd700);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
